// File: rtl/vedic_seq_mul32.sv
// Purpose: 32x32 unsigned multiplier that time-shares one 16x16 Vedic core over four partial products.
// Latency: 4 cycles from accept to out_valid (5 with VEDIC_SEQ_PP_REG_EN); throughput one product per 6 (7) cycles.
// Backpressure: single-entry; in_ready only in IDLE; out_valid/p held in DONE until out_ready.
// Build option: define VEDIC_SEQ_PP_REG_EN to register the 16x16 core output before accumulation.

// 8x8 leaf multiplier used as the base of the Vedic tree.
module vedic8x8 (
    input  logic [7:0]  i_a,
    input  logic [7:0]  i_b,
    output logic [15:0] o_p
);
    assign o_p = {8'd0, i_a} * {8'd0, i_b};
endmodule

// 16x16 Vedic (urdhva-tiryagbhyam) multiplier built from four 8x8 crosswise products.
module vedic16X16 (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    output logic [31:0] o_p
);
    logic [15:0] w_ll;
    logic [15:0] w_lh;
    logic [15:0] w_hl;
    logic [15:0] w_hh;

    vedic8x8 u_ll (.i_a(i_a[7:0]),  .i_b(i_b[7:0]),  .o_p(w_ll));
    vedic8x8 u_lh (.i_a(i_a[7:0]),  .i_b(i_b[15:8]), .o_p(w_lh));
    vedic8x8 u_hl (.i_a(i_a[15:8]), .i_b(i_b[7:0]),  .o_p(w_hl));
    vedic8x8 u_hh (.i_a(i_a[15:8]), .i_b(i_b[15:8]), .o_p(w_hh));

    // Vertical and crosswise terms summed at their weights; the sum fits in 32 bits.
    assign o_p = {16'd0, w_ll}
               + {8'd0, w_lh, 8'd0}
               + {8'd0, w_hl, 8'd0}
               + {w_hh, 16'd0};
endmodule

module vedic_seq_mul32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] p,
    output logic        busy
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  r_step;
    logic        r_issue_done;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [63:0] r_acc;
    logic        r_out_vld;

    logic [15:0] w_x;
    logic [15:0] w_y;
    logic [31:0] w_pp;
    logic        w_issue;
    logic        w_acc_en;
    logic [1:0]  w_acc_step;
    logic [31:0] w_acc_pp;
    logic        w_last;

    // Operand halves selected by the step counter: lo*lo, lo*hi, hi*lo, hi*hi.
    always_comb begin
        w_x = r_a[15:0];
        w_y = r_b[15:0];
        case (r_step)
            2'd0: begin w_x = r_a[15:0];  w_y = r_b[15:0];  end
            2'd1: begin w_x = r_a[15:0];  w_y = r_b[31:16]; end
            2'd2: begin w_x = r_a[31:16]; w_y = r_b[15:0];  end
            default: begin w_x = r_a[31:16]; w_y = r_b[31:16]; end
        endcase
    end

    vedic16X16 u_core (.i_a(w_x), .i_b(w_y), .o_p(w_pp));

    assign w_issue = (r_state == S_MUL) && !r_issue_done;

`ifdef VEDIC_SEQ_PP_REG_EN
    logic [31:0] r_pp;
    logic [1:0]  r_pp_step;
    logic        r_pp_vld;

    // Pipeline register on the core output; accumulation trails issue by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pp      <= 32'd0;
            r_pp_step <= 2'd0;
            r_pp_vld  <= 1'b0;
        end else begin
            r_pp_vld <= w_issue;
            if (w_issue) begin
                r_pp      <= w_pp;
                r_pp_step <= r_step;
            end
        end
    end

    assign w_acc_en   = r_pp_vld;
    assign w_acc_pp   = r_pp;
    assign w_acc_step = r_pp_step;
`else
    assign w_acc_en   = w_issue;
    assign w_acc_pp   = w_pp;
    assign w_acc_step = r_step;
`endif

    // The hi*hi term is always the final accumulate of a product.
    assign w_last = w_acc_en && (w_acc_step == 2'd3);

    // Control FSM: accept/capture, step sequencing, result handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_step       <= 2'd0;
            r_issue_done <= 1'b0;
            r_a          <= 32'd0;
            r_b          <= 32'd0;
            r_out_vld    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a          <= a;
                        r_b          <= b;
                        r_step       <= 2'd0;
                        r_issue_done <= 1'b0;
                        r_state      <= S_MUL;
                    end
                end
                S_MUL: begin
                    if (w_issue) begin
                        r_step <= r_step + 2'd1;
                        if (r_step == 2'd3) begin
                            r_issue_done <= 1'b1;
                        end
                    end
                    if (w_last) begin
                        r_state   <= S_DONE;
                        r_out_vld <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state   <= S_IDLE;
                        r_out_vld <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_out_vld <= 1'b0;
                end
            endcase
        end
    end

    // 64-bit accumulator: partial products added at weights 0, 16, 16, 32.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= 64'd0;
        end else if (w_acc_en) begin
            case (w_acc_step)
                2'd0:    r_acc <= {32'd0, w_acc_pp};
                2'd1,
                2'd2:    r_acc <= r_acc + {16'd0, w_acc_pp, 16'd0};
                default: r_acc <= r_acc + {w_acc_pp, 32'd0};
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign out_valid = r_out_vld;
    assign p         = r_acc;
endmodule

// File: tb/tb_vedic_seq_mul32.sv
// Purpose: self-checking bench for vedic_seq_mul32 (directed table, corner sequences, random scoreboard).
// Latency: expects 4 cycles accept-to-out_valid (5 when VEDIC_SEQ_PP_REG_EN is defined).
// Backpressure: drives random out_ready stalls and in_valid while busy.
module tb_vedic_seq_mul32;
`ifdef VEDIC_SEQ_PP_REG_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 4;
`endif
    localparam int PERIOD = LAT + 2;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] p;
    logic        busy;

    int n_pass;
    int n_total;
    int cyc;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] p;
    } vec_t;

    vedic_seq_mul32 dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .p(p), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        else n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept one operand pair, then wait (bounded) for out_valid; returns p, latency, accept cycle.
    task automatic run_op(input logic [31:0] ia, input logic [31:0] ib,
                          output logic [63:0] got, output int lat, output int t_acc);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin step(); n++; end
        in_valid = 1'b1; a = ia; b = ib;
        step();
        t_acc = cyc;
        in_valid = 1'b0; a = $urandom; b = $urandom;
        lat = 0;
        while (!out_valid && lat < 20) begin step(); lat++; end
        got = p;
    endtask

    vec_t        vt[9];
    logic [63:0] got;
    int          lat;
    int          t_acc;
    int          t_prev;
    logic        ok_p, ok_rdy, ok_vld;
    logic [63:0] q[$];
    logic [63:0] exp_p;
    int          sent, done, guard;
    logic        acc_now, cons_now;

    initial begin
        n_pass = 0; n_total = 0; cyc = 0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        vt[0] = '{32'h0000FFFF, 32'h0000FFFF, 64'h00000000FFFE0001};
        vt[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001};
        vt[2] = '{32'h00010000, 32'h00010000, 64'h0000000100000000};
        vt[3] = '{32'h00000000, 32'hDEADBEEF, 64'h0000000000000000};
        vt[4] = '{32'hFFFFFFFF, 32'h00000001, 64'h00000000FFFFFFFF};
        vt[5] = '{32'h80000000, 32'h00000002, 64'h0000000100000000};
        vt[6] = '{32'hFFFFFFFF, 32'h00010000, 64'h0000FFFFFFFF0000};
        vt[7] = '{32'h00FF00FF, 32'h00000100, 64'h00000000FF00FF00};
        vt[8] = '{32'hFFFF0000, 32'hFFFF0000, 64'hFFFE000100000000};

        // Reset state
        step(); step();
        rst = 1'b0;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_p", p, 64'd0);

        // Directed table, out_ready held high: value, latency, throughput, release
        out_ready = 1'b1;
        t_prev = 0;
        for (int i = 0; i < 9; i++) begin
            run_op(vt[i].a, vt[i].b, got, lat, t_acc);
            chk($sformatf("tbl%0d_p", i), got, vt[i].p);
            chk($sformatf("tbl%0d_lat", i), 64'(lat), 64'(LAT));
            if (i > 0) chk($sformatf("tbl%0d_period", i), 64'(t_acc - t_prev), 64'(PERIOD));
            t_prev = t_acc;
            step();
            chk($sformatf("tbl%0d_release", i), {62'd0, out_valid, in_ready}, 64'b01);
        end

        // Stall in DONE with noise on a/b/in_valid
        out_ready = 1'b0;
        run_op(32'd7, 32'd9, got, lat, t_acc);
        chk("stall_p_first", got, 64'd63);
        ok_p = 1'b1; ok_rdy = 1'b1; ok_vld = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0]; a = $urandom; b = $urandom;
            step();
            if (p !== 64'd63) ok_p = 1'b0;
            if (in_ready !== 1'b0) ok_rdy = 1'b0;
            if (out_valid !== 1'b1) ok_vld = 1'b0;
        end
        chk("stall_p_stable", {63'd0, ok_p}, 64'd1);
        chk("stall_in_ready_low", {63'd0, ok_rdy}, 64'd1);
        chk("stall_out_valid_high", {63'd0, ok_vld}, 64'd1);
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        chk("stall_release_out_valid", {63'd0, out_valid}, 64'd0);
        chk("stall_release_in_ready", {63'd0, in_ready}, 64'd1);
        step();
        chk("stall_no_second_accept", {63'd0, busy}, 64'd0);

        // Reset during step2 abandons the product
        in_valid = 1'b1; a = 32'h1234; b = 32'h5678;
        step();
        in_valid = 1'b0;
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("midrst_p", p, 64'd0);
        ok_vld = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (out_valid !== 1'b0) ok_vld = 1'b0;
            step();
        end
        chk("midrst_no_out_valid", {63'd0, ok_vld}, 64'd1);
        run_op(32'd3, 32'd5, got, lat, t_acc);
        chk("after_rst_3x5", got, 64'd15);
        step();

        // Random back-to-back traffic with random consumer stalls
        sent = 0; done = 0; guard = 0;
        while (done < 1000 && guard < 20000) begin
            in_valid = (sent < 1000);
            a = $urandom; b = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            acc_now  = in_valid && in_ready;
            cons_now = out_valid && out_ready;
            if (acc_now) begin
                q.push_back({32'd0, a} * {32'd0, b});
                sent++;
            end
            if (cons_now) begin
                if (q.size() == 0) begin
                    chk("rnd_spurious_out", {63'd0, out_valid}, 64'd0);
                end else begin
                    exp_p = q.pop_front();
                    chk($sformatf("rnd%0d_p", done), p, exp_p);
                end
                done++;
            end
            step();
            guard++;
        end
        in_valid = 1'b0;
        chk("rnd_all_done", 64'(done), 64'd1000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
